instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Upstream neighbour of the opcode decoder. Holds the PC and fetches each instruction from
//   instruction memory over a req/ready handshake. Presents Instruction[31:0] to the decoder,
//   register file and immediate logic.
//   Takes back the decoder's BranchEQ/BranchNE/Jump and the ALU Zero flag to select the next PC.
// PARAMETERS
//   PC_RESET  32'h0040_0000  PC value loaded on reset (text segment base)
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   imem_req     out  1   fetch request; imem_addr valid while high
//   imem_addr    out  32  byte address of instruction to fetch (= PC)
//   imem_ready   in   1   memory has imem_rdata valid this cycle
//   imem_rdata   in   32  instruction word from memory
//   stall        in   1   hold current instruction in EXEC (datapath not done)
//   BranchEQ     in   1   from decoder: beq in flight
//   BranchNE     in   1   from decoder: bne in flight
//   Jump         in   1   from decoder: j/jal in flight
//   Zero         in   1   ALU zero flag for the instruction in EXEC
//   Instruction  out  32  latched instruction word
//   PC           out  32  address of latched instruction
//   PC_4         out  32  PC+4 (link value for jal)
//   instr_valid  out  1   Instruction valid; datapath may commit this cycle
// BEHAVIOUR
//   Reset (async, reset==0):
//   - PC=PC_RESET, Instruction=0 (decodes as R-type nop), instr_valid=0, imem_req=0, state=FETCH.
//   - Takes effect immediately, even mid-fetch or mid-EXEC. Any in-flight memory response is discarded.
//   FSM, 2 states:
//   - FETCH: imem_req=1, imem_addr=PC, instr_valid=0.
//     - imem_ready=1: latch Instruction<=imem_rdata, go to EXEC.
//     - Otherwise stay in FETCH with PC and address unchanged, for any number of wait cycles.
//   - EXEC: imem_req=0, instr_valid=1.
//     - stall=1: hold PC, Instruction and state.
//     - stall=0: PC<=next_pc, go to FETCH.
//   - imem_ready outside FETCH is ignored.
//   - Minimum latency: 2 cycles per instruction (FETCH with ready in the same cycle, then EXEC).
//   next_pc, evaluated only in EXEC with stall=0 (all arithmetic mod 2^32):
//   - seq    = PC+4. PC=32'hFFFF_FFFC wraps to 0.
//   - branch = PC+4 + {{14{Instruction[15]}},Instruction[15:0],2'b00}
//   - jump   = {PC_4[31:28],Instruction[25:0],2'b00}
//   - take_br = (BranchEQ & Zero) | (BranchNE & ~Zero). If both BranchEQ and BranchNE are high, the branch is always taken.
//   - Priority: Jump > take_br > seq.
//   - Control inputs are sampled only at the EXEC->FETCH edge. Changes during stall have no effect until then.
//   Output timing:
//   - PC_4 is combinational from PC.
//   - imem_addr equals PC at all times.
//   - Outputs change only on a clk edge or on reset assertion.
//   - PC[1:0] is always 2'b00 by construction; no misalignment handling.
// TESTING
//   1 reset=0 then release, imem_ready tied 1, rdata=32'h2008_0005 -> imem_addr=0x0040_0000 in the
//     first FETCH cycle; instr_valid=1 in the 2nd cycle; next fetch at 0x0040_0004.
//   2 imem_ready held low 3 cycles -> imem_req stays 1 and imem_addr is unchanged for 4 cycles;
//     Instruction latched on the 4th cycle.
//   3 EXEC at PC=0x0040_0010, Instruction=32'h1100_FFFE, BranchEQ=1, Zero=1 -> next PC=0x0040_000C.
//     Same stimulus with Zero=0 -> next PC=0x0040_0014.
//   4 EXEC at PC=0x0040_0020, Instruction=32'h0810_0000, Jump=1, BranchNE=1, Zero=0 -> jump wins,
//     next PC=0x0040_0000.
//   5 stall=1 for 5 EXEC cycles while Zero toggles -> PC, Instruction and instr_valid=1 are held;
//     only the values at the stall=0 edge decide next_pc.
//   6 reset pulsed low mid-FETCH with ready pending -> imem_req=0 and PC=PC_RESET in the same
//     cycle; the late ready is ignored.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory fetch bus.
//   imem_req    fetch request; imem_addr is meaningful while high
//   imem_addr   byte address of the instruction being fetched
//   imem_ready  memory presents a valid imem_rdata this cycle
//   imem_rdata  instruction word returned by memory
// master: the fetch unit (drives req/addr). slave: the instruction memory.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction per FETCH/EXEC
// round trip and selects the next PC from the decoder's branch/jump controls.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   imem         instruction-memory bus (master side)
//   stall        hold the current instruction in EXEC
//   BranchEQ     beq in flight
//   BranchNE     bne in flight
//   Jump         j/jal in flight
//   Zero         ALU zero flag for the instruction in EXEC
//   Instruction  latched instruction word
//   PC           address of the latched instruction
//   PC_4         PC+4 (link value for jal)
//   instr_valid  Instruction valid; datapath may commit this cycle
module instruction_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  instruction_fetch_unit_if.master         imem,
  input  logic                             stall,
  input  logic                             BranchEQ,
  input  logic                             BranchNE,
  input  logic                             Jump,
  input  logic                             Zero,
  output logic [31:0]                      Instruction,
  output logic [31:0]                      PC,
  output logic [31:0]                      PC_4,
  output logic                             instr_valid
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t             state;
  state_t             stateNext;
  logic               reqQ;
  logic [31:0]        pcNext;
  logic [31:0]        instrNext;
  logic [31:0]        nextPc;
  logic [31:0]        branchTarget;
  logic [31:0]        jumpTarget;
  logic signed [31:0] branchOff;
  logic               takeBr;

  // Word offset of a branch, sign-extended and scaled to bytes.
  function automatic logic signed [31:0] brOffset(input logic [15:0] imm);
    brOffset = signed'({{14{imm[15]}}, imm, 2'b00});
  endfunction

  assign PC_4           = PC + 32'd4;
  assign branchOff      = brOffset(Instruction[15:0]);
  assign branchTarget   = PC_4 + $unsigned(branchOff);
  assign jumpTarget     = {PC_4[31:28], Instruction[25:0], 2'b00};
  // Both BranchEQ and BranchNE high covers both Zero cases, so it is always taken.
  assign takeBr         = (BranchEQ & Zero) | (BranchNE & ~Zero);
  assign nextPc         = Jump   ? jumpTarget   :
                          takeBr ? branchTarget : PC_4;

  // imem_req is a register so it drops together with reset assertion and
  // rises on the first clock edge after release; a ready seen while the
  // request is low (e.g. a response left over from before reset) is ignored.
  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = PC;
  assign instr_valid    = (state == EXEC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      reqQ        <= 1'b0;
      PC          <= PC_RESET;
      Instruction <= '0;
    end else begin
      state       <= stateNext;
      reqQ        <= (stateNext == FETCH);
      PC          <= pcNext;
      Instruction <= instrNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = PC;
    instrNext = Instruction;
    case (state)
      FETCH: begin
        if (reqQ && imem.imem_ready) begin
          instrNext = imem.imem_rdata;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        // Control inputs only matter on the cycle the stall releases.
        if (!stall) begin
          pcNext    = nextPc;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, BranchEQ, BranchNE, Jump, Zero;
  logic [31:0] Instruction, PC, PC_4;
  logic        instr_valid;

  logic        tieLo;
  logic [31:0] instr2, pc2, pc4_2;
  logic        valid2;

  int nCompared   = 0;
  int nMismatched = 0;

  assign tieLo = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if imem ();
  instruction_fetch_unit_if imem2 ();

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .stall       (stall),
    .BranchEQ    (BranchEQ),
    .BranchNE    (BranchNE),
    .Jump        (Jump),
    .Zero        (Zero),
    .Instruction (Instruction),
    .PC          (PC),
    .PC_4        (PC_4),
    .instr_valid (instr_valid)
  );

  instruction_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dutWrap (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem2.master),
    .stall       (tieLo),
    .BranchEQ    (tieLo),
    .BranchNE    (tieLo),
    .Jump        (tieLo),
    .Zero        (tieLo),
    .Instruction (instr2),
    .PC          (pc2),
    .PC_4        (pc4_2),
    .instr_valid (valid2)
  );

  // Stimulus helpers: present one word with ready for one FETCH cycle, and
  // apply decoder controls for one EXEC cycle.
  task automatic fetchWord(input logic [31:0] word);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = word;
    @(posedge clk); #1;
    imem.imem_ready = 1'b0;
  endtask

  task automatic execStep(input logic j, input logic eq, input logic ne, input logic z);
    Jump = j; BranchEQ = eq; BranchNE = ne; Zero = z;
    @(posedge clk); #1;
    Jump = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0; Zero = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    nCompared++; if (imem.imem_req !== 1'b0) begin nMismatched++; $display("FAIL rst_req: got %0b want 0", imem.imem_req); end
    nCompared++; if (PC !== 32'h0040_0000) begin nMismatched++; $display("FAIL rst_pc: got %h want 00400000", PC); end
    nCompared++; if (imem.imem_addr !== 32'h0040_0000) begin nMismatched++; $display("FAIL rst_addr: got %h want 00400000", imem.imem_addr); end
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
    nCompared++; if (Instruction !== 32'h0) begin nMismatched++; $display("FAIL rst_instr: got %h want 00000000", Instruction); end
    nCompared++; if (PC_4 !== 32'h0040_0004) begin nMismatched++; $display("FAIL rst_pc4: got %h want 00400004", PC_4); end
    @(posedge clk); #1;
    nCompared++; if (imem.imem_req !== 1'b0) begin nMismatched++; $display("FAIL rst_hold_req: got %0b want 0", imem.imem_req); end
  endtask

  task automatic test_wrap;
    imem.imem_ready = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    nCompared++; if (imem2.imem_addr !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_addr: got %h want fffffffc", imem2.imem_addr); end
    nCompared++; if (imem2.imem_req !== 1'b1) begin nMismatched++; $display("FAIL wrap_req: got %0b want 1", imem2.imem_req); end
    @(posedge clk); #1;
    nCompared++; if (valid2 !== 1'b1) begin nMismatched++; $display("FAIL wrap_valid: got %0b want 1", valid2); end
    nCompared++; if (pc4_2 !== 32'h0) begin nMismatched++; $display("FAIL wrap_pc4: got %h want 00000000", pc4_2); end
    @(posedge clk); #1;
    nCompared++; if (pc2 !== 32'h0) begin nMismatched++; $display("FAIL wrap_pc: got %h want 00000000", pc2); end
  endtask

  task automatic test_first_fetch;
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h2008_0005;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    nCompared++; if (imem.imem_req !== 1'b1) begin nMismatched++; $display("FAIL ff_req: got %0b want 1", imem.imem_req); end
    nCompared++; if (imem.imem_addr !== 32'h0040_0000) begin nMismatched++; $display("FAIL ff_addr: got %h want 00400000", imem.imem_addr); end
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("FAIL ff_valid0: got %0b want 0", instr_valid); end
    @(posedge clk); #1;
    nCompared++; if (instr_valid !== 1'b1) begin nMismatched++; $display("FAIL ff_valid1: got %0b want 1", instr_valid); end
    nCompared++; if (Instruction !== 32'h2008_0005) begin nMismatched++; $display("FAIL ff_instr: got %h want 20080005", Instruction); end
    nCompared++; if (imem.imem_req !== 1'b0) begin nMismatched++; $display("FAIL ff_exec_req: got %0b want 0", imem.imem_req); end
    @(posedge clk); #1;
    imem.imem_ready = 1'b0;
    nCompared++; if (imem.imem_addr !== 32'h0040_0004) begin nMismatched++; $display("FAIL ff_next_addr: got %h want 00400004", imem.imem_addr); end
    nCompared++; if (imem.imem_req !== 1'b1) begin nMismatched++; $display("FAIL ff_next_req: got %0b want 1", imem.imem_req); end
  endtask

  task automatic test_wait_states;
    for (int i = 0; i < 4; i++) begin
      nCompared++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0040_0004 || instr_valid !== 1'b0) begin
        nMismatched++;
        $display("FAIL ws_cycle%0d: got req=%0b addr=%h valid=%0b want req=1 addr=00400004 valid=0", i, imem.imem_req, imem.imem_addr, instr_valid);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    fetchWord(32'h0810_0004);
    nCompared++; if (Instruction !== 32'h0810_0004) begin nMismatched++; $display("FAIL ws_instr: got %h want 08100004", Instruction); end
    nCompared++; if (instr_valid !== 1'b1) begin nMismatched++; $display("FAIL ws_valid: got %0b want 1", instr_valid); end
    execStep(1'b1, 1'b0, 1'b0, 1'b0);
    nCompared++; if (imem.imem_addr !== 32'h0040_0010) begin nMismatched++; $display("FAIL ws_jump: got %h want 00400010", imem.imem_addr); end
  endtask

  task automatic test_branch;
    fetchWord(32'h1100_FFFE);
    nCompared++; if (PC !== 32'h0040_0010) begin nMismatched++; $display("FAIL br_pc: got %h want 00400010", PC); end
    execStep(1'b0, 1'b1, 1'b0, 1'b1);
    nCompared++; if (imem.imem_addr !== 32'h0040_000C) begin nMismatched++; $display("FAIL br_eq_taken: got %h want 0040000c", imem.imem_addr); end
    fetchWord(32'h0810_0004);
    execStep(1'b1, 1'b0, 1'b0, 1'b0);
    fetchWord(32'h1100_FFFE);
    execStep(1'b0, 1'b1, 1'b0, 1'b0);
    nCompared++; if (imem.imem_addr !== 32'h0040_0014) begin nMismatched++; $display("FAIL br_eq_not: got %h want 00400014", imem.imem_addr); end
    fetchWord(32'h1100_FFFE);
    execStep(1'b0, 1'b0, 1'b1, 1'b1);
    nCompared++; if (imem.imem_addr !== 32'h0040_0018) begin nMismatched++; $display("FAIL br_ne_not: got %h want 00400018", imem.imem_addr); end
  endtask

  task automatic test_jump_priority;
    fetchWord(32'h0810_0008);
    execStep(1'b1, 1'b0, 1'b0, 1'b0);
    nCompared++; if (imem.imem_addr !== 32'h0040_0020) begin nMismatched++; $display("FAIL jp_setup: got %h want 00400020", imem.imem_addr); end
    fetchWord(32'h0810_0000);
    nCompared++; if (PC_4 !== 32'h0040_0024) begin nMismatched++; $display("FAIL jp_pc4: got %h want 00400024", PC_4); end
    execStep(1'b1, 1'b0, 1'b1, 1'b0);
    nCompared++; if (imem.imem_addr !== 32'h0040_0000) begin nMismatched++; $display("FAIL jp_wins: got %h want 00400000", imem.imem_addr); end
    fetchWord(32'h1100_FFFE);
    execStep(1'b0, 1'b1, 1'b1, 1'b1);
    nCompared++; if (imem.imem_addr !== 32'h003F_FFFC) begin nMismatched++; $display("FAIL jp_both_br: got %h want 003ffffc", imem.imem_addr); end
  endtask

  task automatic test_stall;
    fetchWord(32'h1100_FFFE);
    stall    = 1'b1;
    BranchEQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Zero = (i % 2 == 0);
      @(posedge clk); #1;
      nCompared++; if (PC !== 32'h003F_FFFC || Instruction !== 32'h1100_FFFE || instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin
        nMismatched++;
        $display("FAIL stall_hold%0d: got pc=%h instr=%h valid=%0b req=%0b want pc=003ffffc instr=1100fffe valid=1 req=0",
                 i, PC, Instruction, instr_valid, imem.imem_req);
      end
    end
    stall = 1'b0;
    Zero  = 1'b0;
    @(posedge clk); #1;
    BranchEQ = 1'b0;
    nCompared++; if (imem.imem_addr !== 32'h0040_0000) begin nMismatched++; $display("FAIL stall_release: got %h want 00400000", imem.imem_addr); end
  endtask

  task automatic test_reset_midfetch;
    fetchWord(32'h0810_0004);
    execStep(1'b1, 1'b0, 1'b0, 1'b0);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    #2 reset = 1'b0;
    #1;
    nCompared++; if (imem.imem_req !== 1'b0) begin nMismatched++; $display("FAIL mid_req: got %0b want 0", imem.imem_req); end
    nCompared++; if (PC !== 32'h0040_0000) begin nMismatched++; $display("FAIL mid_pc: got %h want 00400000", PC); end
    nCompared++; if (Instruction !== 32'h0) begin nMismatched++; $display("FAIL mid_instr: got %h want 00000000", Instruction); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    imem.imem_ready = 1'b0;
    nCompared++; if (instr_valid !== 1'b0 || Instruction !== 32'h0) begin
      nMismatched++;
      $display("FAIL mid_late_ready: got valid=%0b instr=%h want valid=0 instr=00000000", instr_valid, Instruction);
    end
    nCompared++; if (imem.imem_req !== 1'b1) begin nMismatched++; $display("FAIL mid_refetch: got %0b want 1", imem.imem_req); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stall = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0; Jump = 1'b0; Zero = 1'b0;
    imem.imem_ready  = 1'b0;
    imem.imem_rdata  = 32'h0;
    imem2.imem_ready = 1'b1;
    imem2.imem_rdata = 32'h0;
    test_reset();
    test_wrap();
    test_first_fetch();
    test_wait_states();
    test_branch();
    test_jump_priority();
    test_stall();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
